// File: rtl/regfile_wb_scoreboard_if.sv
// Signal bundle between issue, the two writeback requesters, the register file write port
// and the writeback scoreboard. The master side drives requests; the scoreboard is the slave.
interface regfile_wb_scoreboard_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
);
   logic             issue_valid;
   logic [4:0]       issue_rs1;
   logic [4:0]       issue_rs2;
   logic [4:0]       issue_rd;
   logic             issue_uses_rs1;
   logic             issue_uses_rs2;
   logic             issue_writes_rd;
   logic             issue_stall;

   logic             alu_valid;
   logic [4:0]       alu_rd;
   logic [XLEN-1:0]  alu_data;
   logic             alu_ready;

   logic             lsu_valid;
   logic [4:0]       lsu_rd;
   logic [XLEN-1:0]  lsu_data;
   logic             lsu_ready;

   logic [4:0]       rf_rd;
   logic             rf_write_enable;
   logic [XLEN-1:0]  rf_write_data;
   logic [NREGS-1:0] busy;
   logic             wb_err;

   modport master (
      output issue_valid, issue_rs1, issue_rs2, issue_rd,
             issue_uses_rs1, issue_uses_rs2, issue_writes_rd,
             alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
      input  issue_stall, alu_ready, lsu_ready,
             rf_rd, rf_write_enable, rf_write_data, busy, wb_err
   );

   modport slave (
      input  issue_valid, issue_rs1, issue_rs2, issue_rd,
             issue_uses_rs1, issue_uses_rs2, issue_writes_rd,
             alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
      output issue_stall, alu_ready, lsu_ready,
             rf_rd, rf_write_enable, rf_write_data, busy, wb_err
   );
endinterface

// File: rtl/regfile_wb_scoreboard.sv
// Register file write-port sequencer: busy-bit scoreboard for RAW/WAW issue stalls and
// round-robin ALU/LSU writeback arbitration with a registered register-file write port.
module regfile_wb_scoreboard #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   regfile_wb_scoreboard_if.slave  wb
);

   typedef enum logic {
      GRANT_ALU = 1'b0,
      GRANT_LSU = 1'b1
   } grant_e;

   grant_e           r_last_grant;
   logic [NREGS-1:0] r_busy;
   logic [4:0]       r_rf_rd;
   logic             r_rf_we;
   logic [XLEN-1:0]  r_rf_data;
   logic             r_wb_err;

   logic             w_stall;
   logic             w_alu_ready;
   logic             w_lsu_ready;
   logic             w_hs;
   logic [4:0]       w_wb_rd;
   logic [XLEN-1:0]  w_wb_data;
   logic [NREGS-1:0] w_set;
   logic [NREGS-1:0] w_clr;
   logic [NREGS-1:0] w_busy_next;
   logic             w_err_hit;

   // NOTE: every signal gets a default at the top of always_comb so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      w_stall     = 1'b0;
      w_alu_ready = 1'b0;
      w_lsu_ready = 1'b0;
      w_set       = '0;
      w_clr       = '0;

      if (!rst) begin
         w_stall = wb.issue_valid &&
                   ((wb.issue_uses_rs1  && r_busy[wb.issue_rs1]) ||
                    (wb.issue_uses_rs2  && r_busy[wb.issue_rs2]) ||
                    (wb.issue_writes_rd && r_busy[wb.issue_rd]));
         // Contention goes to whichever requester did not win the last handshake.
         w_alu_ready = wb.alu_valid && (!wb.lsu_valid || (r_last_grant == GRANT_LSU));
         w_lsu_ready = wb.lsu_valid && (!wb.alu_valid || (r_last_grant == GRANT_ALU));
      end

      w_hs      = w_alu_ready || w_lsu_ready;
      w_wb_rd   = w_alu_ready ? wb.alu_rd   : wb.lsu_rd;
      w_wb_data = w_alu_ready ? wb.alu_data : wb.lsu_data;
      w_err_hit = w_hs && (w_wb_rd != 5'd0) && !r_busy[w_wb_rd];

      if (wb.issue_valid && !w_stall && wb.issue_writes_rd && (wb.issue_rd != 5'd0))
         w_set[wb.issue_rd] = 1'b1;
      // The clear lands on the same edge the register file commits the strobed write.
      if (r_rf_we)
         w_clr[r_rf_rd] = 1'b1;

      w_busy_next    = (r_busy & ~w_clr) | w_set;
      w_busy_next[0] = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy       <= '0;
         r_rf_we      <= 1'b0;
         r_rf_rd      <= '0;
         r_rf_data    <= '0;
         r_wb_err     <= 1'b0;
         r_last_grant <= GRANT_LSU;
      end else begin
         r_busy  <= w_busy_next;
         r_rf_we <= w_hs;
         if (w_hs) begin
            r_rf_rd      <= w_wb_rd;
            r_rf_data    <= w_wb_data;
            r_last_grant <= w_alu_ready ? GRANT_ALU : GRANT_LSU;
         end
         if (w_err_hit)
            r_wb_err <= 1'b1;
      end
   end

   assign wb.issue_stall     = w_stall;
   assign wb.alu_ready       = w_alu_ready;
   assign wb.lsu_ready       = w_lsu_ready;
   assign wb.rf_rd           = r_rf_rd;
   assign wb.rf_write_enable = r_rf_we;
   assign wb.rf_write_data   = r_rf_data;
   assign wb.busy            = r_busy;
   assign wb.wb_err          = r_wb_err;

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Bench for regfile_wb_scoreboard: a behavioural model queues the expected rf write each
// edge and checks it a half cycle later, alongside directed hazard and reset scenarios.
module tb_regfile_wb_scoreboard;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_wb_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

   regfile_wb_scoreboard #(.XLEN(XLEN), .NREGS(NREGS)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (bus)
   );

   int n_vec     = 0;
   int n_miscmp  = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic            we;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } wb_t;

   wb_t              exp_q[$];
   logic [NREGS-1:0] m_busy    = '0;
   logic             m_err     = 1'b0;
   logic             m_last    = 1'b1;   // 1: LSU won last, 0: ALU won last
   logic             m_cur_we  = 1'b0;
   logic [4:0]       m_cur_rd  = '0;
   bit               m_started = 1'b0;

   function automatic logic pred_alu();
      return !rst && bus.alu_valid && (!bus.lsu_valid || m_last);
   endfunction

   function automatic logic pred_lsu();
      return !rst && bus.lsu_valid && (!bus.alu_valid || !m_last);
   endfunction

   function automatic logic pred_stall();
      return !rst && bus.issue_valid &&
             ((bus.issue_uses_rs1  && m_busy[bus.issue_rs1]) ||
              (bus.issue_uses_rs2  && m_busy[bus.issue_rs2]) ||
              (bus.issue_writes_rd && m_busy[bus.issue_rd]));
   endfunction

   // Reference model: advance state at each edge and push the write the rf port owes.
   always @(posedge clk) begin : model_p
      wb_t              e;
      logic [NREGS-1:0] set_v;
      logic [NREGS-1:0] clr_v;
      logic             a_g;
      logic             l_g;
      m_started = 1'b1;
      e = '0;
      if (rst) begin
         m_busy   = '0;
         m_err    = 1'b0;
         m_last   = 1'b1;
         m_cur_we = 1'b0;
      end else begin
         a_g   = pred_alu();
         l_g   = pred_lsu();
         clr_v = '0;
         if (m_cur_we) clr_v[m_cur_rd] = 1'b1;
         set_v = '0;
         if (bus.issue_valid && !pred_stall() && bus.issue_writes_rd && bus.issue_rd != 5'd0)
            set_v[bus.issue_rd] = 1'b1;
         e.we   = a_g | l_g;
         e.rd   = a_g ? bus.alu_rd   : bus.lsu_rd;
         e.data = a_g ? bus.alu_data : bus.lsu_data;
         if (e.we && e.rd != 5'd0 && !m_busy[e.rd]) m_err = 1'b1;
         if (e.we) m_last = l_g;
         m_busy    = (m_busy & ~clr_v) | set_v;
         m_busy[0] = 1'b0;
         m_cur_we  = e.we;
         m_cur_rd  = e.rd;
      end
      exp_q.push_back(e);
   end

   always @(negedge clk) begin : monitor_p
      wb_t e;
      if (m_started) begin
         check("alu_ready",   bus.alu_ready,   pred_alu());
         check("lsu_ready",   bus.lsu_ready,   pred_lsu());
         check("issue_stall", bus.issue_stall, pred_stall());
         check("busy",        bus.busy,        m_busy);
         check("wb_err",      bus.wb_err,      m_err);
         check("wb_q_depth",  exp_q.size(),    1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rf_we", bus.rf_write_enable, e.we);
            if (e.we) begin
               check("rf_rd",   bus.rf_rd,         e.rd);
               check("rf_data", bus.rf_write_data, e.data);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle();
      bus.issue_valid     = 1'b0;
      bus.issue_rs1       = '0;
      bus.issue_rs2       = '0;
      bus.issue_rd        = '0;
      bus.issue_uses_rs1  = 1'b0;
      bus.issue_uses_rs2  = 1'b0;
      bus.issue_writes_rd = 1'b0;
      bus.alu_valid       = 1'b0;
      bus.alu_rd          = '0;
      bus.alu_data        = '0;
      bus.lsu_valid       = 1'b0;
      bus.lsu_rd          = '0;
      bus.lsu_data        = '0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic wr,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
      bus.issue_valid     = 1'b1;
      bus.issue_rd        = rd;
      bus.issue_writes_rd = wr;
      bus.issue_rs1       = rs1;
      bus.issue_uses_rs1  = u1;
      bus.issue_rs2       = rs2;
      bus.issue_uses_rs2  = u2;
   endtask

   task automatic pulse_reset();
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      logic exp_b;
      logic [4:0] exp_rd;
      idle();
      rst = 1'b1;
      step();
      mid();
      check("rst_busy", bus.busy, 32'h0);
      check("rst_we",   bus.rf_write_enable, 1'b0);
      check("rst_rd",   bus.rf_rd, 5'd0);
      check("rst_data", bus.rf_write_data, 32'h0);
      check("rst_err",  bus.wb_err, 1'b0);
      step();
      rst = 1'b0;

      // RAW: x5 producer, then consumer stalls until the x5 strobe cycle has ended
      issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      mid();  check("raw_first_stall", bus.issue_stall, 1'b0);
      step();
      issue(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
      mid();  check("raw_stall_b", bus.issue_stall, 1'b1);
              check("raw_busy5", bus.busy[5], 1'b1);
      step();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h55;
      mid();  check("raw_alu_ready", bus.alu_ready, 1'b1);
              check("raw_stall_c", bus.issue_stall, 1'b1);
      step();
      bus.alu_valid = 1'b0;
      mid();  check("raw_we", bus.rf_write_enable, 1'b1);
              check("raw_rd", bus.rf_rd, 5'd5);
              check("raw_stall_d", bus.issue_stall, 1'b1);
      step();
      mid();  check("raw_stall_e", bus.issue_stall, 1'b0);
              check("raw_busy5_clr", bus.busy[5], 1'b0);
      step();
      idle();

      // Alternating grants under permanent contention, ALU first after reset
      pulse_reset();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'hA;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd2; bus.lsu_data = 32'hB;
      for (int i = 0; i < 6; i++) begin
         exp_b  = (i % 2 == 0);
         exp_rd = (i % 2 == 1) ? 5'd1 : 5'd2;
         mid();
         check($sformatf("rr_alu_%0d", i), bus.alu_ready, exp_b);
         check($sformatf("rr_lsu_%0d", i), bus.lsu_ready, !exp_b);
         if (i > 0) begin
            check($sformatf("rr_we_%0d", i), bus.rf_write_enable, 1'b1);
            check($sformatf("rr_rd_%0d", i), bus.rf_rd, exp_rd);
         end
         step();
      end
      idle();
      mid();  check("rr_last_rd", bus.rf_rd, 5'd2);
              check("rr_last_data", bus.rf_write_data, 32'hB);
      step();

      // WAW on x7
      pulse_reset();
      issue(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      step();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
      mid();  check("waw_stall_b", bus.issue_stall, 1'b1);
      step();
      bus.alu_valid = 1'b0;
      mid();  check("waw_stall_c", bus.issue_stall, 1'b1);
      step();
      mid();  check("waw_stall_d", bus.issue_stall, 1'b0);
      step();
      idle();
      mid();  check("waw_busy7_reset", bus.busy[7], 1'b1);
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h78;
      step();
      idle();
      step();
      step();

      // x0 writeback is harmless; a write to a non-busy register sets the sticky error
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'hFFFF_FFFF;
      mid();  check("x0_lsu_ready", bus.lsu_ready, 1'b1);
      step();
      idle();
      mid();  check("x0_we", bus.rf_write_enable, 1'b1);
              check("x0_rd", bus.rf_rd, 5'd0);
              check("x0_data", bus.rf_write_data, 32'hFFFF_FFFF);
              check("x0_busy", bus.busy, 32'h0);
              check("x0_err", bus.wb_err, 1'b0);
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
      step();
      idle();
      mid();  check("err_set", bus.wb_err, 1'b1);
              check("err_we", bus.rf_write_enable, 1'b1);
              check("err_rd", bus.rf_rd, 5'd9);
      repeat (3) step();
      mid();  check("err_sticky", bus.wb_err, 1'b1);

      // Reset mid-operation discards busy bits and the pending grant
      issue(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      step();
      issue(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      step();
      idle();
      rst = 1'b1;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h33;
      mid();  check("mrst_alu_ready", bus.alu_ready, 1'b0);
              check("mrst_busy_pre", bus.busy[4:3], 2'b11);
      step();
      rst = 1'b0;
      idle();
      issue(5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
      mid();  check("mrst_busy", bus.busy, 32'h0);
              check("mrst_we", bus.rf_write_enable, 1'b0);
              check("mrst_err", bus.wb_err, 1'b0);
              check("mrst_stall", bus.issue_stall, 1'b0);
      step();

      // Stall qualifiers: issue_valid and uses_rs2
      issue(5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      step();
      issue(5'd0, 1'b0, 5'd10, 1'b1, 5'd0, 1'b0);
      bus.issue_valid = 1'b0;
      mid();  check("qual_novalid", bus.issue_stall, 1'b0);
      step();
      issue(5'd0, 1'b0, 5'd0, 1'b1, 5'd10, 1'b0);
      mid();  check("qual_nors2", bus.issue_stall, 1'b0);
      step();
      issue(5'd0, 1'b0, 5'd0, 1'b1, 5'd10, 1'b1);
      mid();  check("qual_rs2", bus.issue_stall, 1'b1);
      step();
      idle();

      // Random traffic checked purely by the model
      for (int i = 0; i < 300; i++) begin
         rst                 = ($urandom_range(0, 49) == 0);
         bus.issue_valid     = $urandom_range(0, 1);
         bus.issue_rs1       = 5'($urandom_range(0, 31));
         bus.issue_rs2       = 5'($urandom_range(0, 31));
         bus.issue_rd        = 5'($urandom_range(0, 31));
         bus.issue_uses_rs1  = $urandom_range(0, 1);
         bus.issue_uses_rs2  = $urandom_range(0, 1);
         bus.issue_writes_rd = $urandom_range(0, 1);
         bus.alu_valid       = $urandom_range(0, 1);
         bus.alu_rd          = 5'($urandom_range(0, 31));
         bus.alu_data        = $urandom;
         bus.lsu_valid       = $urandom_range(0, 1);
         bus.lsu_rd          = 5'($urandom_range(0, 31));
         bus.lsu_data        = $urandom;
         step();
      end
      rst = 1'b0;
      idle();
      repeat (3) step();
      mid();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end
endmodule
